// File: rtl/mux_f_slice_cfgchain.sv
// Wide-function mux slice: configurable 2:1 mux tree over LUT outputs, serial config
// shift chain with shadow->active commit, and an optional output flop per bit.
module mux_f_slice_cfgchain #(
  parameter int MUX_LEVEL = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(1<<MUX_LEVEL)-1:0]   luts_out,
  input  logic [MUX_LEVEL-1:0]        addr,
  input  logic                        ff_ce,
  input  logic                        ff_sr,
  output logic [(1<<MUX_LEVEL)-1:0]   out,
  input  logic                        cfg_en,
  input  logic                        cfg_in,
  output logic                        cfg_out,
  input  logic                        comb_set
);

  localparam int NUM_LUTS = 1 << MUX_LEVEL;
  localparam int CFG_W    = MUX_LEVEL + 2 * NUM_LUTS;

  logic [CFG_W-1:0]    shadow_q, shadow_d;
  logic [CFG_W-1:0]    active_q, active_d;
  logic [NUM_LUTS-1:0] ff_q, ff_d;

  logic [MUX_LEVEL-1:0] mux_en_s;
  logic [NUM_LUTS-1:0]  reg_mode_s;
  logic [NUM_LUTS-1:0]  init_s;
  logic [NUM_LUTS-1:0]  comb_s;

  assign mux_en_s   = active_q[MUX_LEVEL-1:0];
  assign reg_mode_s = active_q[MUX_LEVEL +: NUM_LUTS];
  assign init_s     = active_q[MUX_LEVEL + NUM_LUTS +: NUM_LUTS];

  // Mux tree: at each level the group base bit may take the upper half's base bit.
  always_comb begin
    logic [NUM_LUTS-1:0] cur_v;
    logic [NUM_LUTS-1:0] nxt_v;
    cur_v = luts_out;
    nxt_v = luts_out;
    for (int lv = 1; lv <= MUX_LEVEL; lv++) begin
      nxt_v = cur_v;
      for (int b = 0; b < NUM_LUTS; b += (1 << lv)) begin
        if (mux_en_s[lv-1] && addr[lv-1]) begin
          nxt_v[b] = cur_v[b + (1 << (lv - 1))];
        end else begin
          nxt_v[b] = cur_v[b];
        end
      end
      cur_v = nxt_v;
    end
    comb_s = cur_v;
  end

  // Commit samples the shadow before any same-cycle shift.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    ff_d     = ff_q;
    if (comb_set) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
    if (cfg_en) begin
      shadow_d = {shadow_q[CFG_W-2:0], cfg_in};
    end else begin
      shadow_d = shadow_q;
    end
    if (ff_sr) begin
      ff_d = init_s;
    end else if (ff_ce) begin
      ff_d = comb_s;
    end else begin
      ff_d = ff_q;
    end
  end

  // State registers; reset wins over every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      ff_q     <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      ff_q     <= ff_d;
    end
  end

  assign out     = (reg_mode_s & ff_q) | (~reg_mode_s & comb_s);
  assign cfg_out = shadow_q[CFG_W-1];

endmodule

// File: tb/tb_mux_f_slice_cfgchain.sv
// Self-checking bench for mux_f_slice_cfgchain (MUX_LEVEL=2): spec-level model plus
// a queue scoreboard of expected outputs pushed at drive time.
module tb_mux_f_slice_cfgchain;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] luts_out = 4'b0000;
  logic [1:0] addr = 2'b00;
  logic       ff_ce = 1'b0;
  logic       ff_sr = 1'b0;
  logic [3:0] out;
  logic       cfg_en = 1'b0;
  logic       cfg_in = 1'b0;
  logic       cfg_out;
  logic       comb_set = 1'b0;

  int total = 0;
  int bad = 0;

  logic [9:0] m_shadow = 10'd0;
  logic [9:0] m_active = 10'd0;
  logic [3:0] m_q = 4'd0;

  logic [3:0] exp_q[$];
  logic       exp_b[$];
  logic [3:0] exp_v;
  logic       exp_1;

  mux_f_slice_cfgchain #(.MUX_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .luts_out(luts_out), .addr(addr), .ff_ce(ff_ce),
    .ff_sr(ff_sr), .out(out), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_out(cfg_out), .comb_set(comb_set)
  );

  always #5 clk = ~clk;

  // Trace each output back from the top level to the LUT index it selects.
  function automatic logic [3:0] model_comb(logic [3:0] l, logic [1:0] a, logic [1:0] en);
    logic [3:0] r;
    int idx;
    for (int i = 0; i < 4; i++) begin
      idx = i;
      for (int lv = 2; lv >= 1; lv--) begin
        if ((idx % (1 << lv)) == 0 && en[lv-1] && a[lv-1]) idx = idx + (1 << (lv - 1));
      end
      r[i] = l[idx];
    end
    return r;
  endfunction

  function automatic logic [3:0] m_out();
    logic [3:0] c;
    c = model_comb(luts_out, addr, m_active[1:0]);
    return (m_active[5:2] & m_q) | (~m_active[5:2] & c);
  endfunction

  task automatic tick();
    logic [9:0] ns, na;
    logic [3:0] nq, c;
    c  = model_comb(luts_out, addr, m_active[1:0]);
    ns = m_shadow; na = m_active; nq = m_q;
    if (comb_set) na = m_shadow;
    if (cfg_en) ns = {m_shadow[8:0], cfg_in};
    if (ff_sr) nq = m_active[9:6];
    else if (ff_ce) nq = c;
    if (rst) begin ns = 10'd0; na = 10'd0; nq = 4'd0; end
    @(posedge clk);
    m_shadow = ns; m_active = na; m_q = nq;
    #1;
  endtask

  task automatic shift_word(input logic [9:0] w);
    for (int k = 9; k >= 0; k--) begin
      cfg_en = 1'b1; cfg_in = w[k];
      tick();
    end
    cfg_en = 1'b0; cfg_in = 1'b0;
  endtask

  task automatic commit();
    comb_set = 1'b1;
    tick();
    comb_set = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    luts_out = 4'b1010; addr = 2'b11;
    exp_q.push_back(4'b1010); exp_b.push_back(1'b0);
    #1;
    exp_v = exp_q.pop_front(); exp_1 = exp_b.pop_front();
    total++; if (out !== exp_v) begin bad++; $display("FAIL reset_out got=%b want=%b", out, exp_v); end
    total++; if (cfg_out !== exp_1) begin bad++; $display("FAIL reset_cfg_out got=%b want=%b", cfg_out, exp_1); end
    tick();
  endtask

  task automatic test_mux_tree();
    logic [1:0] at [3];
    logic       e0 [3];
    at[0] = 2'b11; e0[0] = 1'b1;
    at[1] = 2'b01; e0[1] = 1'b0;
    at[2] = 2'b10; e0[2] = 1'b0;
    shift_word(10'b0000_0000_11);
    luts_out = 4'b1000; addr = 2'b11;
    exp_q.push_back(4'b1000);
    #1;
    exp_v = exp_q.pop_front();
    total++; if (out !== exp_v) begin bad++; $display("FAIL shift_no_effect got=%b want=%b", out, exp_v); end
    commit();
    for (int i = 0; i < 3; i++) begin
      luts_out = 4'b1000; addr = at[i];
      exp_b.push_back(e0[i]); exp_q.push_back(m_out());
      #1;
      exp_1 = exp_b.pop_front(); exp_v = exp_q.pop_front();
      total++; if (out[0] !== exp_1) begin bad++; $display("FAIL tree_out0 addr=%b got=%b want=%b", addr, out[0], exp_1); end
      total++; if (out !== exp_v) begin bad++; $display("FAIL tree_out addr=%b got=%b want=%b", addr, out, exp_v); end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      luts_out = 4'($urandom_range(0, 15)); addr = 2'($urandom_range(0, 3));
      exp_q.push_back(m_out());
      #1;
      exp_v = exp_q.pop_front();
      total++; if (out !== exp_v) begin bad++; $display("FAIL tree_rand l=%b a=%b got=%b want=%b", luts_out, addr, out, exp_v); end
      tick();
    end
  endtask

  task automatic test_reg_ff();
    shift_word(10'b1111_0001_01);
    commit();
    luts_out = 4'b1111; addr = 2'b00; ff_sr = 1'b1;
    tick();
    ff_sr = 1'b0;
    exp_b.push_back(1'b1); exp_q.push_back(m_out());
    #1;
    exp_1 = exp_b.pop_front(); exp_v = exp_q.pop_front();
    total++; if (out[0] !== exp_1) begin bad++; $display("FAIL ff_sr_init got=%b want=%b", out[0], exp_1); end
    total++; if (out !== exp_v) begin bad++; $display("FAIL ff_sr_out got=%b want=%b", out, exp_v); end
    ff_ce = 1'b1; luts_out = 4'b0000;
    exp_b.push_back(1'b1);
    #1;
    exp_1 = exp_b.pop_front();
    total++; if (out[0] !== exp_1) begin bad++; $display("FAIL ff_ce_before_edge got=%b want=%b", out[0], exp_1); end
    tick();
    exp_b.push_back(1'b0);
    #1;
    exp_1 = exp_b.pop_front();
    total++; if (out[0] !== exp_1) begin bad++; $display("FAIL ff_ce_capture got=%b want=%b", out[0], exp_1); end
    ff_ce = 1'b0; luts_out = 4'b1111;
    tick(); tick();
    exp_b.push_back(1'b0); exp_q.push_back(m_out());
    #1;
    exp_1 = exp_b.pop_front(); exp_v = exp_q.pop_front();
    total++; if (out[0] !== exp_1) begin bad++; $display("FAIL ff_hold got=%b want=%b", out[0], exp_1); end
    total++; if (out !== exp_v) begin bad++; $display("FAIL ff_hold_out got=%b want=%b", out, exp_v); end
    ff_sr = 1'b1; ff_ce = 1'b1; luts_out = 4'b0000;
    tick();
    ff_sr = 1'b0; ff_ce = 1'b0;
    exp_b.push_back(1'b1);
    #1;
    exp_1 = exp_b.pop_front();
    total++; if (out[0] !== exp_1) begin bad++; $display("FAIL ff_sr_priority got=%b want=%b", out[0], exp_1); end
    tick();
  endtask

  task automatic test_shift_commit_overlap();
    logic [9:0] w;
    w = 10'b1010_0111_00;
    for (int j = 0; j < 10; j++) begin
      cfg_en = 1'b1; cfg_in = w[9-j]; comb_set = (j == 4);
      tick();
      exp_b.push_back(m_shadow[9]);
      #1;
      exp_1 = exp_b.pop_front();
      total++; if (cfg_out !== exp_1) begin bad++; $display("FAIL chain_cfg_out shift=%0d got=%b want=%b", j + 1, cfg_out, exp_1); end
    end
    cfg_en = 1'b0; comb_set = 1'b0;
    exp_b.push_back(w[9]);
    #1;
    exp_1 = exp_b.pop_front();
    total++; if (cfg_out !== exp_1) begin bad++; $display("FAIL chain_first_bit got=%b want=%b", cfg_out, exp_1); end
    for (int i = 0; i < 6; i++) begin
      luts_out = 4'($urandom_range(0, 15)); addr = 2'(i);
      exp_q.push_back(m_out());
      #1;
      exp_v = exp_q.pop_front();
      total++; if (out !== exp_v) begin bad++; $display("FAIL overlap_active l=%b a=%b got=%b want=%b", luts_out, addr, out, exp_v); end
      tick();
    end
  endtask

  task automatic test_reset_mid_shift();
    for (int j = 0; j < 4; j++) begin
      cfg_en = 1'b1; cfg_in = 1'b1;
      tick();
    end
    cfg_en = 1'b1; rst = 1'b1; comb_set = 1'b1; ff_sr = 1'b1;
    tick();
    rst = 1'b0; cfg_en = 1'b0; comb_set = 1'b0; ff_sr = 1'b0;
    luts_out = 4'b0110; addr = 2'b11;
    exp_q.push_back(4'b0110); exp_b.push_back(1'b0);
    #1;
    exp_v = exp_q.pop_front(); exp_1 = exp_b.pop_front();
    total++; if (out !== exp_v) begin bad++; $display("FAIL rst_mid_out got=%b want=%b", out, exp_v); end
    total++; if (cfg_out !== exp_1) begin bad++; $display("FAIL rst_mid_cfg_out got=%b want=%b", cfg_out, exp_1); end
    commit();
    exp_q.push_back(4'b0110);
    #1;
    exp_v = exp_q.pop_front();
    total++; if (out !== exp_v) begin bad++; $display("FAIL rst_mid_commit got=%b want=%b", out, exp_v); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] l;
    shift_word(10'b0000_0000_11);
    commit();
    l = 4'b0110;
    luts_out = l;
    for (int i = 0; i < 8; i++) begin
      addr = 2'(i * 3);
      exp_b.push_back(addr == 2'b11 ? l[3] : addr == 2'b01 ? l[1] : addr == 2'b10 ? l[2] : l[0]);
      #1;
      exp_1 = exp_b.pop_front();
      total++; if (out[0] !== exp_1) begin bad++; $display("FAIL b2b_out0 addr=%b got=%b want=%b", addr, out[0], exp_1); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mux_tree();
    test_reg_ff();
    test_shift_commit_overlap();
    test_reset_mid_shift();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
